// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared encodings for the multicycle RV32I control path.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_ERROR    = 4'd15
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'h03;
    localparam logic [6:0] c_OP_STORE  = 7'h23;
    localparam logic [6:0] c_OP_RTYPE  = 7'h33;
    localparam logic [6:0] c_OP_ITYPE  = 7'h13;
    localparam logic [6:0] c_OP_BRANCH = 7'h63;
    localparam logic [6:0] c_OP_JAL    = 7'h6F;
    localparam logic [6:0] c_OP_JALR   = 7'h67;
    localparam logic [6:0] c_OP_LUI    = 7'h37;
    localparam logic [6:0] c_OP_AUIPC  = 7'h17;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLL  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_SLT  = 4'd8;
    localparam logic [3:0] c_ALU_SLTU = 4'd9;

    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RS1   = 2'b10;
    localparam logic [1:0] c_SRCA_ZERO  = 2'b11;

    localparam logic [1:0] c_SRCB_RS2  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] c_RES_MEMDATA   = 2'b01;
    localparam logic [1:0] c_RES_ALURESULT = 2'b10;

    localparam logic c_ADR_PC     = 1'b0;
    localparam logic c_ADR_RESULT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps funct3/funct7b5/op to the ALU operation code.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import core_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] ALUControl
);

    // Bit 30 is part of the immediate for addi, so SUB is R-type only.
    logic w_is_sub;
    assign w_is_sub = (op == c_OP_RTYPE) && funct7b5;

    always_comb begin
        ALUControl = c_ALU_ADD;
        case (funct3)
            3'b000:  ALUControl = w_is_sub ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  ALUControl = c_ALU_SLL;
            3'b010:  ALUControl = c_ALU_SLT;
            3'b011:  ALUControl = c_ALU_SLTU;
            3'b100:  ALUControl = c_ALU_XOR;
            3'b101:  ALUControl = funct7b5 ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  ALUControl = c_ALU_OR;
            3'b111:  ALUControl = c_ALU_AND;
            default: ALUControl = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main control FSM of the multicycle RV32I core.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import core_pkg::*;
#(
    parameter int HAS_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       Ltu,
    input  logic       MemReady,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemReq,
    output logic       IllegalInstr
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_ready;
    logic       w_taken;
    logic [3:0] w_alu_ctrl;

    assign w_ready = (HAS_MEM_READY != 0) ? MemReady : 1'b1;

    alu_decoder u_alu_decoder (
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUControl (w_alu_ctrl)
    );

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = !Zero;
            3'b100:  w_taken = Lt;
            3'b101:  w_taken = !Lt;
            3'b110:  w_taken = Ltu;
            3'b111:  w_taken = !Ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    w_next_state = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_next_state = S_MEMADR;
                    c_OP_RTYPE:  w_next_state = S_EXECR;
                    c_OP_ITYPE:  w_next_state = S_EXECI;
                    c_OP_BRANCH: w_next_state = (funct3[2:1] == 2'b01) ? S_ERROR : S_BRANCH;
                    c_OP_JAL:    w_next_state = S_JAL;
                    c_OP_JALR:   w_next_state = S_JALR;
                    c_OP_LUI:    w_next_state = S_LUI;
                    c_OP_AUIPC:  w_next_state = S_AUIPC;
                    default:     w_next_state = S_ERROR;
                endcase
            end
            S_MEMADR:   w_next_state = (op == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = w_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL, S_LINK, S_LUI, S_AUIPC:
                        w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            S_JALR:     w_next_state = S_LINK;
            S_ERROR:    w_next_state = S_ERROR;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        ImmSrc       = c_IMM_I;
        ALUSrcA      = c_SRCA_PC;
        ALUSrcB      = c_SRCB_RS2;
        ALUControl   = c_ALU_ADD;
        ResultSrc    = c_RES_ALUOUT;
        AdrSrc       = c_ADR_PC;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        MemReq       = 1'b0;
        IllegalInstr = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = c_SRCB_FOUR;
                ResultSrc = c_RES_ALURESULT;
                IRWrite   = w_ready;
                PCWrite   = w_ready;
            end
            S_DECODE: begin
                // JAL consumes the DECODE-computed target, so it needs the J immediate here.
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_IMM;
                ImmSrc  = (op == c_OP_JAL) ? c_IMM_J : c_IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = c_SRCA_RS1;
                ALUSrcB = c_SRCB_IMM;
                ImmSrc  = (op == c_OP_LOAD) ? c_IMM_I : c_IMM_S;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = c_ADR_RESULT;
            end
            S_MEMWB: begin
                ResultSrc = c_RES_MEMDATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = c_ADR_RESULT;
            end
            S_EXECR: begin
                ALUSrcA    = c_SRCA_RS1;
                ALUControl = w_alu_ctrl;
            end
            S_EXECI: begin
                ALUSrcA    = c_SRCA_RS1;
                ALUSrcB    = c_SRCB_IMM;
                ALUControl = w_alu_ctrl;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = c_SRCA_RS1;
                ALUControl = c_ALU_SUB;
                PCWrite    = w_taken;
            end
            S_JAL: begin
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA   = c_SRCA_RS1;
                ALUSrcB   = c_SRCB_IMM;
                ResultSrc = c_RES_ALURESULT;
                PCWrite   = 1'b1;
            end
            S_LINK: begin
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_FOUR;
            end
            S_LUI: begin
                ALUSrcA = c_SRCA_ZERO;
                ALUSrcB = c_SRCB_IMM;
                ImmSrc  = c_IMM_U;
            end
            S_AUIPC: begin
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_IMM;
                ImmSrc  = c_IMM_U;
            end
            S_ERROR:  IllegalInstr = 1'b1;
            default:  ;
        endcase
        // Reset squashes every request in the same cycle, not one edge later.
        if (reset) begin
            ImmSrc       = 3'b000;
            ALUSrcA      = 2'b00;
            ALUSrcB      = 2'b00;
            ALUControl   = 4'b0000;
            ResultSrc    = 2'b00;
            AdrSrc       = 1'b0;
            IRWrite      = 1'b0;
            PCWrite      = 1'b0;
            RegWrite     = 1'b0;
            MemWrite     = 1'b0;
            MemReq       = 1'b0;
            IllegalInstr = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;
    import core_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        Zero, Lt, Ltu, MemReady;
    logic [2:0]  ImmSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0]  ALUControl;
    logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, MemReq, IllegalInstr;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.HAS_MEM_READY(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (instr[6:0]),
        .funct3       (instr[14:12]),
        .funct7b5     (instr[30]),
        .Zero         (Zero),
        .Lt           (Lt),
        .Ltu          (Ltu),
        .MemReady     (MemReady),
        .ImmSrc       (ImmSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUControl   (ALUControl),
        .ResultSrc    (ResultSrc),
        .AdrSrc       (AdrSrc),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .MemReq       (MemReq),
        .IllegalInstr (IllegalInstr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input state_t exp);
        chk(tag, 32'(dut.r_state), 32'(exp));
    endtask

    // Advance one edge; inputs change 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // From FETCH: present the instruction, move to DECODE and settle.
    task automatic issue(input logic [31:0] ins);
        instr    = ins;
        MemReady = 1'b1;
        cyc();
        #1;
    endtask

    initial begin
        reset = 1'b1; instr = 32'h0; Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; MemReady = 1'b1;
        cyc(); cyc(); #1;
        st("rst_state", S_FETCH);
        chk("rst_irwrite", 32'(IRWrite), 0);
        chk("rst_pcwrite", 32'(PCWrite), 0);
        chk("rst_memreq", 32'(MemReq), 0);
        chk("rst_srcb", 32'(ALUSrcB), 0);
        chk("rst_illegal", 32'(IllegalInstr), 0);

        // addi x1,x0,5
        reset = 1'b0; instr = 32'h00500093; #1;
        chk("f_irwrite", 32'(IRWrite), 1);
        chk("f_pcwrite", 32'(PCWrite), 1);
        chk("f_memreq", 32'(MemReq), 1);
        chk("f_srcb", 32'(ALUSrcB), 2);
        chk("f_ressrc", 32'(ResultSrc), 2);
        cyc(); #1;
        st("addi_dec", S_DECODE);
        chk("dec_srca", 32'(ALUSrcA), 1);
        chk("dec_imm", 32'(ImmSrc), 2);
        chk("dec_regwrite", 32'(RegWrite), 0);
        cyc(); #1;
        st("addi_exec", S_EXECI);
        chk("execi_imm", 32'(ImmSrc), 0);
        chk("execi_srca", 32'(ALUSrcA), 2);
        chk("execi_alu", 32'(ALUControl), 0);
        chk("execi_regwrite", 32'(RegWrite), 0);
        cyc(); #1;
        st("addi_wb", S_ALUWB);
        chk("aluwb_regwrite", 32'(RegWrite), 1);
        cyc(); #1;
        st("addi_fetch", S_FETCH);
        chk("fetch_regwrite", 32'(RegWrite), 0);

        // fetch stall
        MemReady = 1'b0; #1;
        chk("stall_irwrite", 32'(IRWrite), 0);
        chk("stall_pcwrite", 32'(PCWrite), 0);
        cyc(); #1;
        st("stall_state", S_FETCH);

        // lw with 3 wait cycles in MEMREAD
        issue(32'h0040A103);
        cyc(); #1;
        st("lw_memadr", S_MEMADR);
        chk("lw_imm", 32'(ImmSrc), 0);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            st("lw_hold", S_MEMREAD);
            chk("lw_hold_regwrite", 32'(RegWrite), 0);
            chk("lw_adrsrc", 32'(AdrSrc), 1);
        end
        MemReady = 1'b1; #1;
        chk("lw_memreq", 32'(MemReq), 1);
        cyc(); #1;
        st("lw_memwb", S_MEMWB);
        chk("lw_wb_regwrite", 32'(RegWrite), 1);
        chk("lw_wb_ressrc", 32'(ResultSrc), 1);
        cyc(); #1;
        st("lw_fetch", S_FETCH);

        // sw with 2 wait cycles in MEMWRITE
        issue(32'h0020A223);
        cyc(); #1;
        st("sw_memadr", S_MEMADR);
        chk("sw_imm", 32'(ImmSrc), 1);
        MemReady = 1'b0;
        cyc(); #1;
        chk("sw_memwrite0", 32'(MemWrite), 1);
        chk("sw_regwrite", 32'(RegWrite), 0);
        cyc(); #1;
        st("sw_hold", S_MEMWRITE);
        chk("sw_memwrite1", 32'(MemWrite), 1);
        MemReady = 1'b1; #1;
        chk("sw_memwrite2", 32'(MemWrite), 1);
        cyc(); #1;
        st("sw_fetch", S_FETCH);
        chk("sw_done_memwrite", 32'(MemWrite), 0);

        // beq taken
        issue(32'h00000063);
        cyc(); Zero = 1'b1; #1;
        st("beq_state", S_BRANCH);
        chk("beq_pcwrite", 32'(PCWrite), 1);
        chk("beq_alu", 32'(ALUControl), 1);
        chk("beq_srcb", 32'(ALUSrcB), 0);
        cyc(); #1;
        st("beq_fetch", S_FETCH);
        // bne not taken with Zero=1
        issue(32'h00001063);
        cyc(); #1;
        chk("bne_pcwrite", 32'(PCWrite), 0);
        cyc(); Zero = 1'b0;
        // bltu taken
        issue(32'h00006063);
        cyc(); Ltu = 1'b1; #1;
        chk("bltu_pcwrite", 32'(PCWrite), 1);
        cyc(); Ltu = 1'b0;

        // jal
        issue(32'h008000EF);
        chk("jal_dec_imm", 32'(ImmSrc), 3);
        cyc(); #1;
        st("jal_state", S_JAL);
        chk("jal_pcwrite", 32'(PCWrite), 1);
        chk("jal_srca", 32'(ALUSrcA), 1);
        chk("jal_srcb", 32'(ALUSrcB), 2);
        cyc(); #1;
        chk("jal_wb_regwrite", 32'(RegWrite), 1);
        cyc();

        // jalr
        issue(32'h00008067);
        cyc(); #1;
        st("jalr_state", S_JALR);
        chk("jalr_pcwrite", 32'(PCWrite), 1);
        chk("jalr_ressrc", 32'(ResultSrc), 2);
        cyc(); #1;
        st("link_state", S_LINK);
        chk("link_pcwrite", 32'(PCWrite), 0);
        cyc(); #1;
        st("jalr_wb", S_ALUWB);
        cyc(); #1;
        st("jalr_fetch", S_FETCH);

        // lui
        issue(32'h123450B7);
        cyc(); #1;
        chk("lui_imm", 32'(ImmSrc), 4);
        chk("lui_srca", 32'(ALUSrcA), 3);
        cyc(); cyc();

        // sub (R-type), srai
        issue(32'h40208033);
        cyc(); #1;
        st("sub_state", S_EXECR);
        chk("sub_alu", 32'(ALUControl), 1);
        cyc(); cyc();
        issue(32'h4010D093);
        cyc(); #1;
        chk("srai_alu", 32'(ALUControl), 7);
        cyc(); cyc();

        // illegal branch funct3
        issue(32'h00002063);
        cyc(); #1;
        st("bfunct3_err", S_ERROR);
        reset = 1'b1; cyc(); reset = 1'b0; #1;

        // illegal opcode, sticky until reset
        issue(32'h0000007F);
        cyc(); #1;
        st("ill_state", S_ERROR);
        chk("ill_flag", 32'(IllegalInstr), 1);
        chk("ill_enables", {27'd0, IRWrite, PCWrite, RegWrite, MemWrite, MemReq}, 0);
        cyc(); #1;
        chk("ill_sticky", 32'(IllegalInstr), 1);
        reset = 1'b1; #1;
        chk("ill_rst_flag", 32'(IllegalInstr), 0);
        cyc(); reset = 1'b0; #1;
        st("ill_rst_fetch", S_FETCH);

        // reset mid-MEMWRITE
        issue(32'h0020A223);
        cyc(); MemReady = 1'b0;
        cyc(); #1;
        chk("mw_active", 32'(MemWrite), 1);
        reset = 1'b1; #1;
        chk("mw_rst_memwrite", 32'(MemWrite), 0);
        chk("mw_rst_memreq", 32'(MemReq), 0);
        cyc(); reset = 1'b0; MemReady = 1'b1; #1;
        st("mw_rst_fetch", S_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
